// File: rtl/conv_input_feeder.sv
// FIFO-backed stream transmitter feeding the x-input of a conv block, one frame of NUM_VALS samples per start.
// Optional CONV_FEEDER_THROTTLE_EN gates new valids with a 16-bit LFSR for back-pressure testing.
module conv_input_feeder #(
  parameter int T        = 20,
  parameter int DEPTH    = 16,
  parameter int NUM_VALS = 10000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [T-1:0]             ld_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic                     start,
  output logic                     done,
  output logic [T-1:0]             m_data_out_x,
  output logic                     m_valid_x,
  input  logic                     m_ready_x,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [31:0]              sent_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     sent_q, sent_d;
  logic            hold_q, hold_d;
  logic [T-1:0]    mem [DEPTH];

  logic            push;
  logic            pop;
  logic            may_assert;

`ifdef CONV_FEEDER_THROTTLE_EN
  logic [15:0]     lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign may_assert = lfsr_q[0];
`else
  assign may_assert = 1'b1;
`endif

  // Valid depends only on registered state; hold_q keeps an offered sample up until it is taken.
  assign ld_ready     = (count_q != CW'(DEPTH));
  assign push         = ld_valid && ld_ready;
  assign m_valid_x    = (state_q == STREAM) && (count_q != '0) && (hold_q || may_assert);
  assign pop          = m_valid_x && m_ready_x;
  assign m_data_out_x = m_valid_x ? mem[rd_ptr_q] : '0;
  assign done         = (state_q == DONE);
  assign fill_level   = count_q;
  assign sent_count   = sent_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sent_d   = sent_q;
    hold_d   = m_valid_x && !m_ready_x;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      sent_d   = sent_q + 32'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          sent_d  = '0;
        end
      end
      STREAM: begin
        if (pop && (sent_q == 32'(NUM_VALS - 1))) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = STREAM;
          sent_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      hold_q   <= hold_d;
    end
  end

  // Storage array has no reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= ld_data;
  end
endmodule
